// File: rtl/cu_pkg.sv
// Shared control-unit definitions: condition codes, flag bit positions and
// decoder flag-write field layout.
package cu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // flag_w bit positions: one bit per independently written flag pair
    localparam int FLAG_W_NZ = 1;
    localparam int FLAG_W_CV = 0;

endpackage

// File: rtl/condition_check.sv
// Combinational evaluation of an instruction condition field against the
// stored {N,Z,C,V} flags.
module condition_check
    import cu_pkg::*;
#(
    parameter logic NV_EXECUTES = 1'b0
) (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;
    logic ge;

    assign n_flag = flags[FLAG_N];
    assign z_flag = flags[FLAG_Z];
    assign c_flag = flags[FLAG_C];
    assign v_flag = flags[FLAG_V];
    assign ge     = (n_flag == v_flag);

    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = !z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = !c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = !n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = !v_flag;
            COND_HI: cond_ex = c_flag && !z_flag;
            COND_LS: cond_ex = !c_flag || z_flag;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = !ge;
            COND_GT: cond_ex = !z_flag && ge;
            COND_LE: cond_ex = z_flag || !ge;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = NV_EXECUTES;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/conditional_logic.sv
// Status-flag register plus condition gating of the decoder's state-changing
// enables; only instructions whose condition passes update PC, regs, memory or flags.
module conditional_logic
    import cu_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter logic       NV_EXECUTES = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [1:0] nz_reg;
    logic [1:0] cv_reg;
    logic       nz_load;
    logic       cv_load;

    assign flags = {nz_reg, cv_reg};

    // Condition sees the stored flags, so an instruction that both tests and
    // sets flags is evaluated against the values from before its own result.
    condition_check #(
        .NV_EXECUTES (NV_EXECUTES)
    ) u_condition_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign nz_load = en && flag_w[FLAG_W_NZ] && cond_ex;
    assign cv_load = en && flag_w[FLAG_W_CV] && cond_ex;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nz_reg <= RESET_FLAGS[FLAG_N:FLAG_Z];
        end else if (nz_load) begin
            nz_reg <= alu_flags[FLAG_N:FLAG_Z];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cv_reg <= RESET_FLAGS[FLAG_C:FLAG_V];
        end else if (cv_load) begin
            cv_reg <= alu_flags[FLAG_C:FLAG_V];
        end
    end

    assign pc_src    = pcs && cond_ex;
    assign mem_write = mem_w && cond_ex;
    assign reg_write = reg_w && !no_write && cond_ex;

endmodule

// File: tb/tb_conditional_logic.sv
// Directed self-checking bench for conditional_logic: flag updates, condition
// table, enable gating, stall and asynchronous reset.
module tb_conditional_logic;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;

    conditional_logic dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
        $display("check %s: observed %b expected %b", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] table_a;
    logic [15:0] table_b;

    initial begin
        table_a = 16'h6A69;  // expected cond_ex per cond for flags 0101
        table_b = 16'h6996;  // expected cond_ex per cond for flags 1010

        rst = 1'b0; en = 1'b1; cond = 4'hE; alu_flags = 4'h0; flag_w = 2'b00;
        pcs = 1'b0; reg_w = 1'b1; mem_w = 1'b0; no_write = 1'b0;
        #2;
        check("reset_flags", flags, 4'b0000);
        check("reset_reg_write", {3'b0, reg_write}, 4'd1);
        check("reset_pc_src", {3'b0, pc_src}, 4'd0);
        #6 rst = 1'b1;
        step();
        check("release_flags", flags, 4'b0000);

        // ADDS setting Z
        flag_w = 2'b11; alu_flags = 4'b0100;
        step();
        check("adds_flags", flags, 4'b0100);
        flag_w = 2'b00; cond = 4'h0; #1;
        check("eq_cond_ex", {3'b0, cond_ex}, 4'd1);
        check("eq_reg_write", {3'b0, reg_write}, 4'd1);
        cond = 4'h1; #1;
        check("ne_cond_ex", {3'b0, cond_ex}, 4'd0);
        check("ne_reg_write", {3'b0, reg_write}, 4'd0);

        // N,Z only
        cond = 4'hE; flag_w = 2'b10; alu_flags = 4'b1011;
        step();
        check("nz_only_flags", flags, 4'b1000);

        // Same-cycle test and set uses old flags
        cond = 4'hB; flag_w = 2'b11; alu_flags = 4'b0000; #1;
        check("lt_old_flags", {3'b0, cond_ex}, 4'd1);
        step();
        check("lt_write_flags", flags, 4'b0000);
        flag_w = 2'b00; #1;
        check("lt_new_flags", {3'b0, cond_ex}, 4'd0);

        // Failed condition suppresses every side effect
        cond = 4'h0; pcs = 1'b1; mem_w = 1'b1; flag_w = 2'b11; alu_flags = 4'b1111; #1;
        check("fail_pc_src", {3'b0, pc_src}, 4'd0);
        check("fail_mem_write", {3'b0, mem_write}, 4'd0);
        step();
        check("fail_flags_hold", flags, 4'b0000);
        cond = 4'h1; flag_w = 2'b00; #1;
        check("pass_pc_src", {3'b0, pc_src}, 4'd1);
        check("pass_mem_write", {3'b0, mem_write}, 4'd1);

        // no_write and stall
        pcs = 1'b0; mem_w = 1'b0; cond = 4'hE; no_write = 1'b1; #1;
        check("no_write_reg_write", {3'b0, reg_write}, 4'd0);
        no_write = 1'b0; #1;
        check("al_reg_write", {3'b0, reg_write}, 4'd1);
        en = 1'b0; flag_w = 2'b11; alu_flags = 4'b0101;
        step();
        check("stall_flags_hold", flags, 4'b0000);
        en = 1'b1;
        step();
        check("cv_nz_write", flags, 4'b0101);

        flag_w = 2'b00;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i); #1;
            check($sformatf("table_a_%0d", i), {3'b0, cond_ex}, {3'b0, table_a[i]});
        end

        cond = 4'hE; flag_w = 2'b01; alu_flags = 4'b1010;
        step();
        check("cv_only_flags", flags, 4'b0110);
        flag_w = 2'b10;
        step();
        check("nz_to_1010", flags, 4'b1010);
        flag_w = 2'b00;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i); #1;
            check($sformatf("table_b_%0d", i), {3'b0, cond_ex}, {3'b0, table_b[i]});
        end

        // Async reset mid-cycle with X on control inputs
        cond = 4'hE; step();
        #2 rst = 1'b0; cond = 4'bxxxx; flag_w = 2'bxx; alu_flags = 4'b1111;
        #1;
        check("async_reset_flags", flags, 4'b0000);
        step();
        check("reset_hold_edge", flags, 4'b0000);
        #2 rst = 1'b1; cond = 4'hE; flag_w = 2'b00;
        step();
        check("post_release_flags", flags, 4'b0000);
        #1;
        check("post_release_reg_write", {3'b0, reg_write}, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
